// File: rtl/shift_sched_if.sv
// ---------------------------------------------------------------------------
// shift_sched_if
// Purpose : bundles the two requester channels and the shift-register control
//           outputs of shift_sched into a single port.
// Signals :
//   req_a / req_b   requester transfer request, held until its grant is seen
//   din_a / din_b   requester parallel data (8 bit), stable while req is high
//   dir_a / dir_b   requester shift direction, 0 = right, 1 = left
//   gnt_a / gnt_b   one-cycle grant pulse to the accepted requester
//   sel             shift-register mode: 00 hold, 01 right, 10 left, 11 load
//   dout            parallel load data, valid while sel = 11
//   busy            high from LOAD through DONE inclusive
//   done            one-cycle transfer-complete pulse
// Modports: master = requester / shift-register side, slave = scheduler.
// ---------------------------------------------------------------------------
interface shift_sched_if;
  localparam int unsigned DW = 8;

  logic          req_a;
  logic [DW-1:0] din_a;
  logic          dir_a;
  logic          req_b;
  logic [DW-1:0] din_b;
  logic          dir_b;

  logic          gnt_a;
  logic          gnt_b;
  logic [1:0]    sel;
  logic [DW-1:0] dout;
  logic          busy;
  logic          done;

  modport master (
    output req_a, din_a, dir_a,
    output req_b, din_b, dir_b,
    input  gnt_a, gnt_b, sel, dout, busy, done
  );

  modport slave (
    input  req_a, din_a, dir_a,
    input  req_b, din_b, dir_b,
    output gnt_a, gnt_b, sel, dout, busy, done
  );
endinterface

// File: rtl/shift_sched.sv
// ---------------------------------------------------------------------------
// shift_sched
// Purpose : arbitrates between two requesters and sequences an external shift
//           register through one parallel load followed by SHIFT_LEN shifts.
//           Flow per transfer: IDLE -> LOAD -> SHIFT x SHIFT_LEN -> DONE -> IDLE.
// Ports   :
//   clk_i   system clock, all state changes on the rising edge
//   rst_i   synchronous active-high reset; aborts any transfer, no done pulse
//   bus     shift_sched_if.slave (requests in, grant/sel/dout/busy/done out)
// Params  : SHIFT_LEN  shift cycles per transfer, legal range 0..8
// Config  : SHIFT_SCHED_FIXED_PRIORITY_EN  when defined, A always wins
//           simultaneous requests and the round-robin pointer is removed;
//           when undefined, round-robin arbitration is used.
// All outputs are registered.
// ---------------------------------------------------------------------------
module shift_sched #(
  parameter int unsigned SHIFT_LEN = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  shift_sched_if.slave  bus
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  localparam logic [CW-1:0] LEN_C = CW'(SHIFT_LEN);

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [DW-1:0] dout_q,  dout_d;
  logic          dir_q,   dir_d;
  logic [1:0]    sel_q,   sel_d;
  logic          gnt_a_q, gnt_a_d;
  logic          gnt_b_q, gnt_b_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic          any_req_c;
  logic          win_b_c;

  assign any_req_c = bus.req_a | bus.req_b;

  // Arbitration: decide whether B wins the current IDLE sample.
`ifdef SHIFT_SCHED_FIXED_PRIORITY_EN
  // B is only accepted when A is not asking.
  assign win_b_c = ~bus.req_a;
`else
  logic last_b_q, last_b_d;

  // B wins when alone, or when both ask and A was the last one served.
  assign win_b_c = bus.req_b & (~bus.req_a | ~last_b_q);
`endif

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so that every output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dir_d   = dir_q;
    sel_d   = sel_q;
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifndef SHIFT_SCHED_FIXED_PRIORITY_EN
    last_b_d = last_b_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        sel_d  = SEL_HOLD;
        busy_d = 1'b0;
        if (any_req_c) begin
          state_d = S_LOAD;
          sel_d   = SEL_LOAD;
          busy_d  = 1'b1;
          dout_d  = win_b_c ? bus.din_b : bus.din_a;
          dir_d   = win_b_c ? bus.dir_b : bus.dir_a;
          gnt_a_d = ~win_b_c;
          gnt_b_d = win_b_c;
          cnt_d   = LEN_C;
`ifndef SHIFT_SCHED_FIXED_PRIORITY_EN
          // Pointer moves together with the grant, i.e. as LOAD is entered.
          last_b_d = win_b_c;
`endif
        end
      end

      S_LOAD: begin
        busy_d = 1'b1;
        if (LEN_C != CW'(0)) begin
          state_d = S_SHIFT;
          sel_d   = dir_q ? SEL_LEFT : SEL_RIGHT;
        end else begin
          state_d = S_DONE;
          sel_d   = SEL_HOLD;
          done_d  = 1'b1;
        end
      end

      S_SHIFT: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q - CW'(1);
        // Counter holds the shifts still to run including the current one.
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
          sel_d   = SEL_HOLD;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        sel_d   = SEL_HOLD;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        sel_d   = SEL_HOLD;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      dir_q   <= 1'b0;
      sel_q   <= SEL_HOLD;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifndef SHIFT_SCHED_FIXED_PRIORITY_EN
      // Pointing at B makes A win the first contention.
      last_b_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      sel_q   <= sel_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifndef SHIFT_SCHED_FIXED_PRIORITY_EN
      last_b_q <= last_b_d;
`endif
    end
  end

  assign bus.gnt_a = gnt_a_q;
  assign bus.gnt_b = gnt_b_q;
  assign bus.sel   = sel_q;
  assign bus.dout  = dout_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_shift_sched.sv
// ---------------------------------------------------------------------------
// tb_shift_sched
// Three schedulers (SHIFT_LEN 8, 3, 0) share clock and reset. Stimulus pushes
// the expected transfer into a per-instance queue; a monitor on the falling
// edge pops it at each grant and follows the transfer through LOAD, SHIFT,
// DONE and the trailing IDLE cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shift_sched;

  typedef struct packed {
    logic       who_b;
    logic [7:0] data;
    logic       dir;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0]      req_a, req_b, dir_a, dir_b;
  logic [2:0][7:0] din_a, din_b;

  wire  [2:0]      gnt_a_w, gnt_b_w, busy_w, done_w;
  wire  [2:0][1:0] sel_w;
  wire  [2:0][7:0] dout_w;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   phase[3];
  int   left[3];
  int   pending[3];
  exp_t cur[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LEN = (g == 0) ? 8 : ((g == 1) ? 3 : 0);
    shift_sched_if bus ();
    assign bus.req_a = req_a[g];
    assign bus.din_a = din_a[g];
    assign bus.dir_a = dir_a[g];
    assign bus.req_b = req_b[g];
    assign bus.din_b = din_b[g];
    assign bus.dir_b = dir_b[g];
    assign gnt_a_w[g] = bus.gnt_a;
    assign gnt_b_w[g] = bus.gnt_b;
    assign sel_w[g]   = bus.sel;
    assign dout_w[g]  = bus.dout;
    assign busy_w[g]  = bus.busy;
    assign done_w[g]  = bus.done;
    shift_sched #(.SHIFT_LEN(LEN)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
    );
  end

  function automatic int len_of(input int g);
    return (g == 0) ? 8 : ((g == 1) ? 3 : 0);
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, g, act, exp, $time);
    end
  endtask

  task automatic push(input int g, input exp_t e);
    case (g)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    pending[g]++;
  endtask

  function automatic int qsize(input int g);
    case (g)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop(input int g);
    case (g)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Scoreboard monitor: follows every granted transfer cycle by cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        phase[g] = 0;
      end else begin
        case (phase[g])
          0: begin
            if (done_w[g]) chk("stray_done", g, 32'(done_w[g]), 0);
            if (gnt_a_w[g] | gnt_b_w[g]) begin
              if (qsize(g) == 0) begin
                chk("unexpected_gnt", g, 32'({gnt_a_w[g], gnt_b_w[g]}), 0);
              end else begin
                cur[g] = pop(g);
                chk("gnt_a", g, 32'(gnt_a_w[g]), 32'(!cur[g].who_b));
                chk("gnt_b", g, 32'(gnt_b_w[g]), 32'(cur[g].who_b));
                chk("load_sel", g, 32'(sel_w[g]), 3);
                chk("load_dout", g, 32'(dout_w[g]), 32'(cur[g].data));
                chk("load_busy", g, 32'(busy_w[g]), 1);
                chk("load_done", g, 32'(done_w[g]), 0);
                left[g]  = len_of(g);
                phase[g] = (left[g] > 0) ? 1 : 2;
              end
            end
          end
          1: begin
            chk("shift_sel", g, 32'(sel_w[g]), cur[g].dir ? 2 : 1);
            chk("shift_busy", g, 32'(busy_w[g]), 1);
            chk("shift_gnt", g, 32'({gnt_a_w[g], gnt_b_w[g]}), 0);
            chk("shift_done", g, 32'(done_w[g]), 0);
            chk("shift_dout", g, 32'(dout_w[g]), 32'(cur[g].data));
            left[g]--;
            if (left[g] == 0) phase[g] = 2;
          end
          2: begin
            chk("done_pulse", g, 32'(done_w[g]), 1);
            chk("done_sel", g, 32'(sel_w[g]), 0);
            chk("done_busy", g, 32'(busy_w[g]), 1);
            chk("done_gnt", g, 32'({gnt_a_w[g], gnt_b_w[g]}), 0);
            chk("done_dout", g, 32'(dout_w[g]), 32'(cur[g].data));
            phase[g] = 3;
          end
          default: begin
            chk("idle_busy", g, 32'(busy_w[g]), 0);
            chk("idle_done", g, 32'(done_w[g]), 0);
            chk("idle_gnt", g, 32'({gnt_a_w[g], gnt_b_w[g]}), 0);
            chk("idle_sel", g, 32'(sel_w[g]), 0);
            phase[g] = 0;
            pending[g]--;
          end
        endcase
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input int g);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cyc(1);
      if (gnt_a_w[g] | gnt_b_w[g]) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout dut%0d: no grant within 50 cycles", g);
    end
  endtask

  task automatic wait_gnts(input int g, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      cyc(1);
      if (gnt_a_w[g] | gnt_b_w[g]) seen++;
    end
    chk("gnt_count", g, 32'(seen), 32'(n));
  endtask

  task automatic drain(input int g);
    for (int i = 0; i < 200 && pending[g] != 0; i++) cyc(1);
    chk("drain", g, 32'(pending[g]), 0);
  endtask

  initial begin
    int bc;
    int dc;
    rst   = 1'b1;
    req_a = '0; req_b = '0; dir_a = '0; dir_b = '0;
    din_a = '0; din_b = '0;
    cyc(2);

    // Reset values on all instances.
    for (int g = 0; g < 3; g++) begin
      chk("rst_sel", g, 32'(sel_w[g]), 0);
      chk("rst_dout", g, 32'(dout_w[g]), 0);
      chk("rst_gnt_a", g, 32'(gnt_a_w[g]), 0);
      chk("rst_gnt_b", g, 32'(gnt_b_w[g]), 0);
      chk("rst_busy", g, 32'(busy_w[g]), 0);
      chk("rst_done", g, 32'(done_w[g]), 0);
    end
    rst = 1'b0;

    // Single A transfer, 8 right shifts.
    din_a[0] = 8'h4A; dir_a[0] = 1'b0;
    push(0, '{who_b: 1'b0, data: 8'h4A, dir: 1'b0});
    req_a[0] = 1'b1;
    wait_gnt(0);
    req_a[0] = 1'b0;
    drain(0);

    // Both held from reset: round-robin A,B,A (fixed priority: A,A,A).
    do_reset();
    din_a[0] = 8'hDA; dir_a[0] = 1'b0;
    din_b[0] = 8'hEA; dir_b[0] = 1'b1;
`ifdef SHIFT_SCHED_FIXED_PRIORITY_EN
    push(0, '{who_b: 1'b0, data: 8'hDA, dir: 1'b0});
    push(0, '{who_b: 1'b0, data: 8'hDA, dir: 1'b0});
    push(0, '{who_b: 1'b0, data: 8'hDA, dir: 1'b0});
`else
    push(0, '{who_b: 1'b0, data: 8'hDA, dir: 1'b0});
    push(0, '{who_b: 1'b1, data: 8'hEA, dir: 1'b1});
    push(0, '{who_b: 1'b0, data: 8'hDA, dir: 1'b0});
`endif
    req_a[0] = 1'b1;
    req_b[0] = 1'b1;
    wait_gnts(0, 3);
    req_a[0] = 1'b0;
    req_b[0] = 1'b0;
    drain(0);

    // Lone B right after reset (pointer at B), left shifts, SHIFT_LEN 3.
    do_reset();
    din_b[1] = 8'h3C; dir_b[1] = 1'b1;
    push(1, '{who_b: 1'b1, data: 8'h3C, dir: 1'b1});
    req_b[1] = 1'b1;
    wait_gnt(1);
    req_b[1] = 1'b0;
    bc = 1;
    for (int i = 0; i < 20 && busy_w[1]; i++) begin
      cyc(1);
      if (busy_w[1]) bc++;
    end
    chk("busy_len", 1, 32'(bc), 5);
    drain(1);

    // SHIFT_LEN 0: LOAD then DONE back to back.
    din_a[2] = 8'hEF; dir_a[2] = 1'b0;
    push(2, '{who_b: 1'b0, data: 8'hEF, dir: 1'b0});
    req_a[2] = 1'b1;
    wait_gnt(2);
    req_a[2] = 1'b0;
    drain(2);

    // Request still held after Done is served again after one IDLE cycle.
    din_a[2] = 8'h11; dir_a[2] = 1'b1;
    push(2, '{who_b: 1'b0, data: 8'h11, dir: 1'b1});
    push(2, '{who_b: 1'b0, data: 8'h11, dir: 1'b1});
    req_a[2] = 1'b1;
    wait_gnts(2, 2);
    req_a[2] = 1'b0;
    drain(2);

    // Reset in the 4th SHIFT cycle aborts the transfer without Done.
    do_reset();
    din_a[0] = 8'h5A; dir_a[0] = 1'b1;
    push(0, '{who_b: 1'b0, data: 8'h5A, dir: 1'b1});
    req_a[0] = 1'b1;
    wait_gnt(0);
    req_a[0] = 1'b0;
    cyc(4);
    chk("abort_pre_sel", 0, 32'(sel_w[0]), 2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    pending[0] = 0;
    chk("abort_sel", 0, 32'(sel_w[0]), 0);
    chk("abort_busy", 0, 32'(busy_w[0]), 0);
    chk("abort_dout", 0, 32'(dout_w[0]), 0);
    chk("abort_done", 0, 32'(done_w[0]), 0);
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (done_w[0]) dc++;
    end
    chk("abort_no_done", 0, 32'(dc), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
